// File: rtl/multi_step_counter_pkg.sv
// ---------------------------------------------------------------------------
// multi_step_counter_pkg
// Shared definitions for the load/decrement counter family.
//   DEFAULT_WIDTH / DEFAULT_CHANNELS : default accumulator width and count
//   ZERO_VALUE                      : value an accumulator holds after reset
//   chan_idx_t                      : channel index type for the default
//                                     channel count
// ---------------------------------------------------------------------------
package multi_step_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 4;
    localparam int unsigned DEFAULT_CHANNELS = 4;
    localparam int unsigned ZERO_VALUE       = 0;

    typedef logic [$clog2(DEFAULT_CHANNELS)-1:0] chan_idx_t;

endpackage

// File: rtl/multi_step_counter_step_sub.sv
// ---------------------------------------------------------------------------
// step_sub
// Combinational WIDTH-bit subtract with borrow detection and a
// saturate/wrap select applied to the result.
//   minuend_i    : current accumulator value
//   subtrahend_i : decrement step
//   result_o     : new accumulator value (0 on borrow when SATURATE = 1,
//                  modulo 2^WIDTH otherwise)
//   borrow_o     : high when subtrahend_i > minuend_i
// ---------------------------------------------------------------------------
module step_sub
    import multi_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] minuend_i,
    input  logic [WIDTH-1:0] subtrahend_i,
    output logic [WIDTH-1:0] result_o,
    output logic             borrow_o
);

    logic [WIDTH:0] diffWide;

    // Subtract one bit wider than the operands so the top bit of the
    // difference is the borrow; the low bits are already the wrapped result.
    always_comb begin
        diffWide = {1'b0, minuend_i} - {1'b0, subtrahend_i};
        borrow_o = diffWide[WIDTH];
        if (SATURATE && diffWide[WIDTH]) begin
            result_o = WIDTH'(ZERO_VALUE);
        end else begin
            result_o = diffWide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multi_step_counter.sv
// ---------------------------------------------------------------------------
// multi_step_counter
// CHANNELS independent WIDTH-bit accumulators, each loadable from data_in
// and decremented by a programmable step. A round-robin pointer selects the
// channel that load/enable act on.
//   clock     : rising-edge clock
//   rst       : synchronous active-high reset
//   enable    : decrement the active channel by decre_in
//   load      : write data_in into the active channel (wins over enable)
//   next      : advance the pointer after this cycle's operation
//   data_in   : load value
//   decre_in  : decrement step
//   data_out  : value of the active channel
//   chan_idx  : active channel pointer
//   underflow : one-cycle pulse following a borrowing decrement
//   done_mask : bit i set when channel i holds zero
//   all_done  : every channel holds zero
// ---------------------------------------------------------------------------
module multi_step_counter
    import multi_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        load,
    input  logic                        next,
    input  logic [WIDTH-1:0]            data_in,
    input  logic [WIDTH-1:0]            decre_in,
    output logic [WIDTH-1:0]            data_out,
    output logic [$clog2(CHANNELS)-1:0] chan_idx,
    output logic                        underflow,
    output logic [CHANNELS-1:0]         done_mask,
    output logic                        all_done
);

    localparam int unsigned IDX_W = $clog2(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    logic [WIDTH-1:0] acc_q [CHANNELS];
    logic [WIDTH-1:0] acc_d [CHANNELS];
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             underflow_q;
    logic             underflow_d;

    logic [WIDTH-1:0] subResult;
    logic             subBorrow;

    // A single subtractor serves whichever channel the pointer selects.
    step_sub #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) uStepSub (
        .minuend_i    (acc_q[ptr_q]),
        .subtrahend_i (decre_in),
        .result_o     (subResult),
        .borrow_o     (subBorrow)
    );

    // Next-state: only the channel under the current (pre-advance) pointer
    // may change, load beats enable, and the pointer advances independently
    // of whatever operation happened this cycle.
    always_comb begin
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        underflow_d = 1'b0;
        if (load) begin
            acc_d[ptr_q] = data_in;
        end else if (enable) begin
            acc_d[ptr_q] = subResult;
            underflow_d  = subBorrow;
        end
        if (next) begin
            ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
        end
    end

    // State registers; reset overrides any operation sampled on the same edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                acc_q[i] <= WIDTH'(ZERO_VALUE);
            end
            ptr_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            underflow_q <= underflow_d;
        end
    end

    // Zero status is decoded purely from the registered accumulators so no
    // input reaches an output without passing a register.
    always_comb begin
        done_mask = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            done_mask[i] = (acc_q[i] == WIDTH'(ZERO_VALUE));
        end
    end

    assign data_out  = acc_q[ptr_q];
    assign chan_idx  = ptr_q;
    assign underflow = underflow_q;
    assign all_done  = &done_mask;

endmodule

// File: tb/tb_multi_step_counter.sv
// ---------------------------------------------------------------------------
// tb_multi_step_counter
// Drives a saturating (instance 0) and a wrapping (instance 1) counter with
// the same directed stimulus and compares both against a behavioural model
// on every falling edge, plus hand-computed expectations along the way.
// ---------------------------------------------------------------------------
module tb_multi_step_counter;
    import multi_step_counter_pkg::*;

    logic clock;
    logic rst;
    logic enable;
    logic load;
    logic next;
    logic [3:0] dataIn;
    logic [3:0] decreIn;

    logic [3:0] dataOut   [2];
    chan_idx_t  chanIdx   [2];
    logic       underflow [2];
    logic [3:0] doneMask  [2];
    logic       allDone   [2];

    int checks;
    int errors;
    bit checking;

    int accM [2][4];
    int ptrM;
    int ufM  [2];

    multi_step_counter #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b1)) dutSat (
        .clock     (clock),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .next      (next),
        .data_in   (dataIn),
        .decre_in  (decreIn),
        .data_out  (dataOut[0]),
        .chan_idx  (chanIdx[0]),
        .underflow (underflow[0]),
        .done_mask (doneMask[0]),
        .all_done  (allDone[0])
    );

    multi_step_counter #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b0)) dutWrap (
        .clock     (clock),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .next      (next),
        .data_in   (dataIn),
        .decre_in  (decreIn),
        .data_out  (dataOut[1]),
        .chan_idx  (chanIdx[1]),
        .underflow (underflow[1]),
        .done_mask (doneMask[1]),
        .all_done  (allDone[1])
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model of one edge: plain integer arithmetic on both
    // instances, instance 0 clamps and instance 1 wraps on underflow.
    task automatic modelEdge(input bit r, input bit ld, input bit en, input bit nx,
                             input int din, input int dec);
        if (r) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 4; c++) accM[s][c] = 0;
                ufM[s] = 0;
            end
            ptrM = 0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (ld) begin
                    accM[s][ptrM] = din;
                    ufM[s] = 0;
                end else if (en) begin
                    if (dec > accM[s][ptrM]) begin
                        accM[s][ptrM] = (s == 0) ? 0 : accM[s][ptrM] - dec + 16;
                        ufM[s] = 1;
                    end else begin
                        accM[s][ptrM] = accM[s][ptrM] - dec;
                        ufM[s] = 0;
                    end
                end else begin
                    ufM[s] = 0;
                end
            end
            if (nx) ptrM = (ptrM + 1) % 4;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // return on the following falling edge with outputs settled.
    task automatic applyStimulus(input bit r, input bit ld, input bit en, input bit nx,
                                 input int din, input int dec);
        rst     = r;
        load    = ld;
        enable  = en;
        next    = nx;
        dataIn  = 4'(din);
        decreIn = 4'(dec);
        @(posedge clock);
        modelEdge(r, ld, en, nx, din, dec);
        @(negedge clock);
        rst    = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
        next   = 1'b0;
    endtask

    // Hand-computed expectations for one instance.
    task automatic checkOutput(input string name, input int s, input int expData,
                               input int expIdx, input int expUf, input int expMask);
        int expAll;
        expAll = (expMask == 15) ? 1 : 0;
        checks++;
        if (int'(dataOut[s]) != expData || int'(chanIdx[s]) != expIdx ||
            int'(underflow[s]) != expUf || int'(doneMask[s]) != expMask ||
            int'(allDone[s]) != expAll) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got data=%0d idx=%0d uf=%0d mask=%b all=%0d, want data=%0d idx=%0d uf=%0d mask=%b all=%0d",
                     name, s, dataOut[s], chanIdx[s], underflow[s], doneMask[s], allDone[s],
                     expData, expIdx, expUf, 4'(expMask), expAll);
        end
    endtask

    // Every falling edge once the model is initialised: both instances
    // against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (checking) begin
                for (int s = 0; s < 2; s++) begin
                    int expMask;
                    expMask = 0;
                    for (int c = 0; c < 4; c++) if (accM[s][c] == 0) expMask |= (1 << c);
                    checks++;
                    if (int'(dataOut[s]) != accM[s][ptrM] || int'(chanIdx[s]) != ptrM ||
                        int'(underflow[s]) != ufM[s] || int'(doneMask[s]) != expMask ||
                        int'(allDone[s]) != ((expMask == 15) ? 1 : 0)) begin
                        errors++;
                        $display("[TB] FAIL model inst%0d t=%0t: got data=%0d idx=%0d uf=%0d mask=%b, want data=%0d idx=%0d uf=%0d mask=%b",
                                 s, $time, dataOut[s], chanIdx[s], underflow[s], doneMask[s],
                                 accM[s][ptrM], ptrM, ufM[s], 4'(expMask));
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        checks   = 0;
        errors   = 0;
        checking = 1'b0;
        ptrM     = 0;
        rst      = 1'b0;
        load     = 1'b0;
        enable   = 1'b0;
        next     = 1'b0;
        dataIn   = '0;
        decreIn  = '0;
        @(negedge clock);

        applyStimulus(1, 1, 0, 0, 7, 0);
        applyStimulus(1, 1, 0, 0, 7, 0);
        checking = 1'b1;
        checkOutput("reset", 0, 0, 0, 0, 4'b1111);
        checkOutput("reset", 1, 0, 0, 0, 4'b1111);

        applyStimulus(0, 1, 0, 0, 10, 0);
        checkOutput("load10", 0, 10, 0, 0, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 3);
        checkOutput("sat_dec1", 0, 7, 0, 0, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 3);
        applyStimulus(0, 0, 1, 0, 0, 3);
        checkOutput("sat_dec3", 0, 1, 0, 0, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 3);
        checkOutput("sat_clamp", 0, 0, 0, 1, 4'b1111);
        checkOutput("wrap_from1", 1, 14, 0, 1, 4'b1110);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("uf_pulse_end", 0, 0, 0, 0, 4'b1111);

        applyStimulus(0, 1, 0, 0, 2, 0);
        applyStimulus(0, 0, 1, 0, 0, 3);
        checkOutput("wrap_2m3", 1, 15, 0, 1, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 15);
        checkOutput("wrap_15m15", 1, 0, 0, 0, 4'b1111);
        checkOutput("sat_back2back", 0, 0, 0, 1, 4'b1111);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 1, 9, 0);
        checkOutput("load_next", 0, 0, 1, 0, 4'b1110);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("next_2", 0, 0, 2, 0, 4'b1110);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("next_wrap", 0, 9, 0, 0, 4'b1110);

        applyStimulus(0, 1, 1, 0, 5, 2);
        checkOutput("load_priority", 0, 5, 0, 0, 4'b1110);
        applyStimulus(0, 0, 1, 0, 0, 5);
        checkOutput("dec_equal", 1, 0, 0, 0, 4'b1111);
        applyStimulus(0, 1, 0, 0, 6, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("dec_zero", 0, 6, 0, 0, 4'b1110);

        applyStimulus(0, 1, 0, 1, 3, 0);
        applyStimulus(0, 1, 0, 0, 8, 0);
        checkOutput("two_nonzero", 0, 8, 1, 0, 4'b1100);
        applyStimulus(1, 1, 1, 1, 4, 1);
        checkOutput("reset_mid", 0, 0, 0, 0, 4'b1111);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("post_reset_sat", 0, 0, 0, 1, 4'b1111);
        checkOutput("post_reset_wrap", 1, 15, 0, 1, 4'b1110);
        applyStimulus(0, 0, 0, 0, 0, 0);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
